// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter sharing one line-wide physical-memory port
// between the I-cache and D-cache, one line transaction at a time, with a sticky timeout.
module pmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_SET     = CNT_W'(MAX_WAIT - 1);

  state_e              state_q;
  logic                last_d_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rd_q;
  logic                wr_q;
  logic                timeout_q;

  logic i_req;
  logic d_req;
  logic pick_i;

  assign i_req  = i_read;
  assign d_req  = d_read | d_write;
  // On a tie the side that did not win last time goes next.
  assign pick_i = i_req & (~d_req | last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            cnt_q   <= '0;
            wdata_q <= d_wdata;
            if (pick_i) begin
              state_q <= GRANT_I;
              addr_q  <= i_address & ~OFFSET_MASK;
              rd_q    <= 1'b1;
            end else begin
              state_q <= GRANT_D;
              addr_q  <= d_address & ~OFFSET_MASK;
              rd_q    <= ~d_write;
              wr_q    <= d_write;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          // Saturating wait counter; the transaction keeps waiting after a timeout.
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_SET) timeout_q <= 1'b1;
          if (pmem_resp) begin
            state_q  <= RELEASE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            last_d_q <= (state_q == GRANT_D);
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_resp       = pmem_resp & (state_q == GRANT_I);
  assign d_resp       = pmem_resp & (state_q == GRANT_D);
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - randomized bench for pmem_arbiter against a line-memory and
// round-robin reference model.
module tb_pmem_arbiter;
  localparam int MW = 8;

  logic         clk;
  logic         rst_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic         i_resp;
  logic [127:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic         d_resp;
  logic [127:0] d_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         timeout_err;

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .OFFSET_W(4), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] phys    [4096];
  logic [127:0] exp_mem [4096];
  bit           exp_last_d;
  bit           mem_mute;
  int           late_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical memory: random 1..4 cycle latency, or silent until a late response is asked for.
  initial begin
    int cnt;
    int lat;
    int late_done;
    cnt = 0; lat = 1; late_done = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        if (mem_mute) begin
          if (late_cnt != late_done) begin
            late_done = late_cnt;
            pmem_resp = 1'b1;
            if (pmem_read) pmem_rdata = phys[pmem_address[15:4]];
          end
        end else begin
          if (cnt == 0) lat = $urandom_range(1, 4);
          cnt++;
          if (cnt == lat) begin
            pmem_resp = 1'b1;
            if (pmem_write) phys[pmem_address[15:4]] = pmem_wdata;
            else pmem_rdata = phys[pmem_address[15:4]];
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_resp(output bit ok, output bit gi, output bit gd,
                           output logic [127:0] rdi, output logic [127:0] rdd,
                           output int first, output logic [15:0] a, output bit wr,
                           output logic [127:0] wd);
    ok = 0; gi = 0; gd = 0; rdi = '0; rdd = '0; first = 0; a = '0; wr = 0; wd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (first == 0 && (pmem_read || pmem_write)) begin
        first = c; a = pmem_address; wr = pmem_write; wd = pmem_wdata;
      end
      if (i_resp || d_resp) begin
        ok = 1; gi = i_resp; gd = d_resp; rdi = i_rdata; rdd = d_rdata;
        break;
      end
    end
  endtask

  task automatic idle();
    i_read = 0; d_read = 0; d_write = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; i_read = 0; d_read = 0; d_write = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_last_d = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++;
      $display("FAIL reset_strobes: got rd=%b wr=%b required 0 0", pmem_read, pmem_write); end
    apply_reset();
    @(negedge clk);
    checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++;
      $display("FAIL reset_resps: got i=%b d=%b required 0 0", i_resp, d_resp); end
    checks++; if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL reset_timeout: got %b required 0", timeout_err); end
    checks++; if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin errors++;
      $display("FAIL reset_latches: got addr=%h wdata=%h required 0", pmem_address, pmem_wdata); end
  endtask

  task automatic test_i_read();
    bit ok, gi, gd, wr; logic [127:0] rdi, rdd, wd; int first; logic [15:0] a;
    i_read = 1; i_address = 16'h1236;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || first != 1 || wr !== 1'b0) begin errors++;
      $display("FAIL iread_strobe: got ok=%0d first=%0d wr=%b required 1 1 0", ok, first, wr); end
    checks++; if (a !== 16'h1230) begin errors++;
      $display("FAIL iread_addr: got %h required 1230", a); end
    checks++; if (gi !== 1'b1 || gd !== 1'b0 || rdi !== exp_mem[12'h123]) begin errors++;
      $display("FAIL iread_resp: got i=%b d=%b data=%h required 1 0 %h", gi, gd, rdi, exp_mem[12'h123]); end
    @(negedge clk);
    checks++; if (i_resp !== 1'b0) begin errors++;
      $display("FAIL iread_pulse: got i_resp=%b one cycle later required 0", i_resp); end
    exp_last_d = 0;
    i_read = 0;
    @(negedge clk);
  endtask

  task automatic test_d_write();
    bit ok, gi, gd, wr; logic [127:0] rdi, rdd, wd; int first; logic [15:0] a;
    logic [127:0] line;
    line = {16{8'hA5}};
    d_write = 1; d_address = 16'h20A4; d_wdata = line;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || first != 1 || wr !== 1'b1 || a !== 16'h20A0) begin errors++;
      $display("FAIL dwrite_strobe: got ok=%0d first=%0d wr=%b addr=%h required 1 1 1 20a0", ok, first, wr, a); end
    checks++; if (wd !== line || gd !== 1'b1 || gi !== 1'b0) begin errors++;
      $display("FAIL dwrite_data: got wdata=%h i=%b d=%b required %h 0 1", wd, gi, gd, line); end
    exp_mem[12'h20A] = line;
    exp_last_d = 1;
    idle();
    d_read = 1; d_address = 16'h20A4;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || gd !== 1'b1 || rdd !== exp_mem[12'h20A]) begin errors++;
      $display("FAIL dwrite_readback: got d=%b data=%h required 1 %h", gd, rdd, exp_mem[12'h20A]); end
    idle();
  endtask

  task automatic test_random();
    bit ok, gi, gd, wr; logic [127:0] rdi, rdd, wd; int first; logic [15:0] a;
    for (int n = 0; n < 24; n++) begin
      int k; logic [15:0] ad; logic [127:0] dat; bit is_wr;
      k = $urandom_range(0, 3);
      ad = 16'($urandom);
      dat = {$urandom, $urandom, $urandom, $urandom};
      is_wr = (k >= 2);
      if (k == 0) begin i_read = 1; i_address = ad; end
      else begin d_read = (k != 2); d_write = is_wr; d_address = ad; d_wdata = dat; end
      wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
      checks++; if (!ok || first != 1 || a !== {ad[15:4], 4'h0} || wr !== is_wr) begin errors++;
        $display("FAIL rand_req%0d: got ok=%0d first=%0d addr=%h wr=%b required 1 1 %h %b",
                 n, ok, first, a, wr, {ad[15:4], 4'h0}, is_wr); end
      checks++; if (gi !== (k == 0) || gd !== (k != 0)) begin errors++;
        $display("FAIL rand_owner%0d: got i=%b d=%b required i=%b", n, gi, gd, k == 0); end
      if (is_wr) begin
        checks++; if (wd !== dat) begin errors++;
          $display("FAIL rand_wdata%0d: got %h required %h", n, wd, dat); end
        exp_mem[ad[15:4]] = dat;
      end else begin
        checks++; if (((k == 0) ? rdi : rdd) !== exp_mem[ad[15:4]]) begin errors++;
          $display("FAIL rand_rdata%0d: got %h required %h", n, (k == 0) ? rdi : rdd, exp_mem[ad[15:4]]); end
      end
      exp_last_d = (k != 0);
      idle();
    end
  endtask

  task automatic test_back_to_back();
    bit ok, gi, gd, wr; logic [127:0] rdi, rdd, wd; int first; logic [15:0] a;
    logic [15:0] ia, da;
    apply_reset();
    ia = 16'($urandom); da = 16'($urandom);
    i_read = 1; i_address = ia; d_read = 1; d_address = da;
    for (int t = 0; t < 3; t++) begin
      bit win_i;
      logic [15:0] wa;
      win_i = exp_last_d;
      wa = win_i ? ia : da;
      wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
      checks++; if (!ok || gi !== win_i || gd !== !win_i) begin errors++;
        $display("FAIL tie_order%0d: got i=%b d=%b required i=%b", t, gi, gd, win_i); end
      checks++; if (first != ((t == 0) ? 1 : 3)) begin errors++;
        $display("FAIL tie_gap%0d: got strobe at cycle %0d required %0d", t, first, (t == 0) ? 1 : 3); end
      checks++; if (a !== {wa[15:4], 4'h0} || (win_i ? rdi : rdd) !== exp_mem[wa[15:4]]) begin errors++;
        $display("FAIL tie_data%0d: got addr=%h data=%h required %h %h", t, a, win_i ? rdi : rdd,
                 {wa[15:4], 4'h0}, exp_mem[wa[15:4]]); end
      exp_last_d = !win_i;
    end
    idle();
  endtask

  task automatic test_drop();
    bit ok, gi, gd, wr; logic [127:0] rdi, rdd, wd; int first; logic [15:0] a; int seen;
    mem_mute = 1;
    d_read = 1; d_address = 16'h4440;
    @(negedge clk);
    i_read = 1; i_address = 16'h5550;
    @(negedge clk);
    i_read = 0;
    late_cnt++;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || gd !== 1'b1 || gi !== 1'b0) begin errors++;
      $display("FAIL drop_before_dresp: got ok=%0d i=%b d=%b required 1 0 1", ok, gi, gd); end
    d_read = 0;
    exp_last_d = 1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (pmem_read || pmem_write) seen++; end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL drop_before_grant: got %0d strobe cycles required 0", seen); end
    i_read = 1; i_address = 16'h5558;
    @(negedge clk);
    i_read = 0;
    late_cnt++;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || gi !== 1'b1 || rdi !== exp_mem[12'h555]) begin errors++;
      $display("FAIL drop_after_grant: got ok=%0d i=%b data=%h required 1 1 %h", ok, gi, rdi, exp_mem[12'h555]); end
    exp_last_d = 0;
    mem_mute = 0;
    idle();
  endtask

  task automatic test_timeout();
    bit ok, gi, gd, wr; logic [127:0] rdi, rdd, wd; int first; logic [15:0] a;
    logic e_before, e_after;
    mem_mute = 1;
    d_read = 1; d_address = 16'h7778;
    e_before = 1'bx;
    for (int c = 1; c <= MW; c++) begin @(negedge clk); e_before = timeout_err; end
    @(negedge clk);
    e_after = timeout_err;
    checks++; if (e_before !== 1'b0 || e_after !== 1'b1) begin errors++;
      $display("FAIL timeout_edge: got %b then %b required 0 then 1", e_before, e_after); end
    repeat (5) @(negedge clk);
    checks++; if (pmem_read !== 1'b1 || timeout_err !== 1'b1) begin errors++;
      $display("FAIL timeout_wait: got rd=%b err=%b required 1 1", pmem_read, timeout_err); end
    late_cnt++;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || gd !== 1'b1 || rdd !== exp_mem[12'h777]) begin errors++;
      $display("FAIL timeout_late_resp: got ok=%0d d=%b data=%h required 1 1 %h", ok, gd, rdd, exp_mem[12'h777]); end
    exp_last_d = 1;
    mem_mute = 0;
    idle();
    checks++; if (timeout_err !== 1'b1) begin errors++;
      $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic test_mid_reset();
    bit ok, gi, gd, wr; logic [127:0] rdi, rdd, wd; int first; logic [15:0] a;
    apply_reset();
    checks++; if (timeout_err !== 1'b0) begin errors++;
      $display("FAIL midrst_clear: got err=%b required 0", timeout_err); end
    mem_mute = 1;
    d_write = 1; d_address = 16'h3334; d_wdata = {4{$urandom}};
    repeat (2) @(negedge clk);
    checks++; if (pmem_write !== 1'b1) begin errors++;
      $display("FAIL midrst_grant: got wr=%b required 1", pmem_write); end
    rst_n = 0;
    #1;
    checks++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || d_resp !== 1'b0) begin errors++;
      $display("FAIL midrst_drop: got wr=%b rd=%b d_resp=%b required 0 0 0", pmem_write, pmem_read, d_resp); end
    d_write = 0;
    @(negedge clk);
    rst_n = 1;
    exp_last_d = 1;
    mem_mute = 0;
    i_read = 1; i_address = 16'h6660; d_read = 1; d_address = 16'h3334;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || gi !== 1'b1 || gd !== 1'b0 || rdi !== exp_mem[12'h666]) begin errors++;
      $display("FAIL midrst_tie: got ok=%0d i=%b d=%b data=%h required 1 1 0 %h", ok, gi, gd, rdi, exp_mem[12'h666]); end
    exp_last_d = 0;
    i_read = 0;
    wait_resp(ok, gi, gd, rdi, rdd, first, a, wr, wd);
    checks++; if (!ok || gd !== 1'b1 || rdd !== exp_mem[12'h333]) begin errors++;
      $display("FAIL midrst_next: got ok=%0d d=%b data=%h required 1 1 %h", ok, gd, rdd, exp_mem[12'h333]); end
    idle();
  endtask

  initial begin
    rst_n = 0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; mem_mute = 0; late_cnt = 0; exp_last_d = 1;
    for (int k = 0; k < 4096; k++) begin
      phys[k] = {$urandom, $urandom, $urandom, $urandom};
      exp_mem[k] = phys[k];
    end
    test_reset();
    test_i_read();
    test_d_write();
    test_random();
    test_back_to_back();
    test_drop();
    test_timeout();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
